axi_wr_slave_ram: RTL and testbench

- AXI3 write-channel responder (AW/W/B) that accepts one burst at a time and commits beats into a word-addressed synchronous RAM through byte write enables.
- Other end of the cache/write-buffer AXI write master: it is the memory-side target for line write-backs (8-beat INCR bursts) and uncached single-beat stores.
- It is used as the simulation/FPGA memory model and as the write port of on-chip scratch RAM.
- One outstanding burst; the read channel is out of scope.

---
 rtl/axi_defs_pkg.sv | 43 ++++
 rtl/axi_burst_addr_gen.sv | 32 +++
 rtl/axi_wr_slave_ram.sv | 140 ++++++++++++++
 tb/tb_axi_wr_slave_ram.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_defs_pkg.sv
// Shared AXI3 write-channel definitions: field widths, burst/response codes,
// the latched AW descriptor and the response-priority helper.
package axi_defs;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;
  localparam logic [BURST_W-1:0] BURST_RSVD  = 2'b11;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } wr_state_e;

  // Burst descriptor held for the duration of one write burst
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [LEN_W-1:0]   len;
    logic [SIZE_W-1:0]  size;
    logic [BURST_W-1:0] burst;
  } aw_req_t;

  // Response codes are ordered so the numerically larger one has priority
  function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] a,
                                                   input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts;
// the reserved burst type steps like INCR.
module axi_burst_addr_gen
  import axi_defs::*;
(
  input  logic [ADDR_W-1:0]  cur_addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr_c
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    step = ADDR_W'(1) << size;
    span = (ADDR_W'(len) + ADDR_W'(1)) << size;
    mask = span - ADDR_W'(1);
    incr = cur_addr + step;
    next_addr_c = incr;
    case (burst)
      BURST_FIXED: next_addr_c = cur_addr;
      // Low bits count modulo the wrap span, upper bits stay put
      BURST_WRAP:  next_addr_c = (cur_addr & ~mask) | (incr & mask);
      default:     next_addr_c = incr;
    endcase
  end

endmodule

// File: rtl/axi_wr_slave_ram.sv
// AXI3 write responder: one burst at a time, beats committed to a synchronous
// word-addressed RAM in the same cycle as the W handshake.
module axi_wr_slave_ram
  import axi_defs::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] ADDR_BYTES = 32'h0001_0000,
  parameter int unsigned RAM_AW     = 14
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [SIZE_W-1:0]   awsize,
  input  logic [BURST_W-1:0]  awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [STRB_W-1:0]   wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [RESP_W-1:0]   bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                ram_en,
  output logic [STRB_W-1:0]   ram_wen,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata
);

  wr_state_e         state_q, state_d;
  aw_req_t           aw_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] next_addr_c;
  logic [LEN_W-1:0]  cnt_q;
  logic [RESP_W-1:0] err_q;

  logic              aw_fire;
  logic              beat_fire;
  logic              last_beat;
  logic              burst_bad;
  logic              in_range;
  logic [ADDR_W-1:0] offset;
  logic [RESP_W-1:0] beat_err;

  // W channel ID is not used: no write interleaving
  logic unused_bits;
  assign unused_bits = ^{wid, offset[1:0], offset[ADDR_W-1:RAM_AW+2]};

  axi_burst_addr_gen u_addr_gen (
    .cur_addr    (cur_addr_q),
    .size        (aw_q.size),
    .len         (aw_q.len),
    .burst       (aw_q.burst),
    .next_addr_c (next_addr_c)
  );

  assign aw_fire   = awvalid && awready;
  assign beat_fire = wvalid && wready;

  // Per-beat legality and error classification
  always_comb begin
    last_beat = (cnt_q == aw_q.len);
    burst_bad = 1'b0;
    if (aw_q.size > 3'd2) burst_bad = 1'b1;
    if (aw_q.burst == BURST_RSVD) burst_bad = 1'b1;
    if (aw_q.burst == BURST_WRAP &&
        !(aw_q.len == 4'd1 || aw_q.len == 4'd3 || aw_q.len == 4'd7 || aw_q.len == 4'd15))
      burst_bad = 1'b1;
    offset   = cur_addr_q - ADDR_BASE;
    in_range = (offset < ADDR_BYTES);
    beat_err = RESP_OKAY;
    if (burst_bad || (wlast != last_beat)) beat_err = RESP_SLVERR;
    if (!in_range) beat_err = RESP_DECERR;
  end

  // Zero-latency RAM port, quiet whenever no beat is being taken
  always_comb begin
    ram_en    = beat_fire;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (beat_fire) begin
      ram_wen   = (!burst_bad && in_range) ? wstrb : '0;
      ram_addr  = offset[RAM_AW+1:2];
      ram_wdata = wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (aw_fire) state_d = S_DATA;
      S_DATA:  if (beat_fire && last_beat) state_d = S_RESP;
      S_RESP:  if (bvalid && bready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      state_q <= state_d;
      awready <= (state_d == S_IDLE);
      wready  <= (state_d == S_DATA);
      bvalid  <= (state_d == S_RESP);
    end
  end

  // Burst descriptor, address walker, beat counter and sticky response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_q       <= '0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      err_q      <= RESP_OKAY;
    end else if (aw_fire) begin
      aw_q       <= '{id: awid, len: awlen, size: awsize, burst: awburst};
      cur_addr_q <= awaddr;
      cnt_q      <= '0;
      err_q      <= RESP_OKAY;
    end else if (beat_fire) begin
      cur_addr_q <= next_addr_c;
      cnt_q      <= LEN_W'(cnt_q + LEN_W'(1));
      err_q      <= resp_merge(err_q, beat_err);
    end
  end

  assign bid   = aw_q.id;
  assign bresp = err_q;

endmodule

// File: tb/tb_axi_wr_slave_ram.sv
// Bench for axi_wr_slave_ram: table of directed bursts, hand sequences for
// B back-pressure and mid-burst reset, then random bursts against a model.
module tb_axi_wr_slave_ram;
  import axi_defs::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BYTES = 32'h0001_0000;
  localparam int unsigned RAW   = 14;
  localparam int unsigned WORDS = 1 << RAW;

  logic        clk, rstn;
  logic [3:0]  awid, wid, bid;
  logic [31:0] awaddr, wdata, ram_wdata;
  logic [3:0]  awlen, wstrb, ram_wen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, ram_en;
  logic [RAW-1:0] ram_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          len;
    int          size;
    int          burst;
    logic [3:0]  strb;
    logic [31:0] wbase;
    int          last_at;
    logic [1:0]  resp;
  } vec_t;

  vec_t        tbl[13];
  vec_t        g_v;
  logic        g_bad;
  logic [31:0] dut_mem [WORDS];
  logic [31:0] exp_mem [WORDS];
  logic [31:0] tb_w;

  axi_wr_slave_ram #(.ADDR_BASE(BASE), .ADDR_BYTES(BYTES), .RAM_AW(RAW)) dut (
    .clk(clk), .rstn(rstn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM on the DUT's memory port
  always @(posedge clk) begin
    if (ram_en) begin
      tb_w = dut_mem[ram_addr];
      for (int b = 0; b < 4; b++) if (ram_wen[b]) tb_w[8*b +: 8] = ram_wdata[8*b +: 8];
      dut_mem[ram_addr] = tb_w;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Address of beat i computed directly from the burst rules
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] nb, span, wb;
    nb   = 32'd1 << size;
    span = 32'(len + 1) * nb;
    if (burst == 0) return start;
    if (burst == 2) begin
      wb = start - (start % span);
      return wb + ((start - wb + 32'(i) * nb) % span);
    end
    return start + 32'(i) * nb;
  endfunction

  function automatic logic is_bad(input int len, input int size, input int burst);
    return (size > 2) || (burst == 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [1:0] model_resp(input vec_t v);
    logic [1:0] r;
    r = (is_bad(v.len, v.size, v.burst) || v.last_at != v.len) ? RESP_SLVERR : RESP_OKAY;
    for (int i = 0; i <= v.len; i++)
      if (beat_addr(v.addr, v.len, v.size, v.burst, i) - BASE >= BYTES) r = RESP_DECERR;
    return r;
  endfunction

  task automatic aw_phase(input vec_t v);
    int n;
    g_v   = v;
    g_bad = is_bad(v.len, v.size, v.burst);
    awid = v.id; awaddr = v.addr; awlen = 4'(v.len); awsize = 3'(v.size);
    awburst = 2'(v.burst); awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", 32'(awready), 1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    chk("awready_busy", 32'(awready), 0);
  endtask

  task automatic w_phase(input int nbeats);
    int n, idx;
    logic [31:0] a, off;
    logic [3:0]  ewen;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1; wdata = g_v.wbase + 32'(i); wstrb = g_v.strb;
      wlast = (i == g_v.last_at);
      n = 0;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      chk("w_accept", 32'(wready), 1);
      #1;
      a    = beat_addr(g_v.addr, g_v.len, g_v.size, g_v.burst, i);
      off  = a - BASE;
      ewen = (!g_bad && off < BYTES) ? g_v.strb : 4'h0;
      idx  = int'(off[RAW+1:2]);
      chk("ram_en", 32'(ram_en), 1);
      chk("ram_wen", 32'(ram_wen), 32'(ewen));
      chk("awready_in_data", 32'(awready), 0);
      if (ewen != 0) begin
        chk("ram_addr", 32'(ram_addr), 32'(off[RAW+1:2]));
        chk("ram_wdata", ram_wdata, wdata);
        for (int b = 0; b < 4; b++) if (ewen[b]) exp_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
      @(posedge clk); @(negedge clk);
      if (ewen != 0) chk("mem_word", dut_mem[idx], exp_mem[idx]);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] exp_resp, input int hold);
    int n;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("bvalid", 32'(bvalid), 1);
    chk("bid", 32'(bid), 32'(g_v.id));
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("awready_in_resp", 32'(awready), 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bvalid), 1);
      chk("bid_hold", 32'(bid), 32'(g_v.id));
      chk("bresp_hold", 32'(bresp), 32'(exp_resp));
      chk("awready_hold", 32'(awready), 0);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    chk("bvalid_done", 32'(bvalid), 0);
    chk("awready_after_b", 32'(awready), 1);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    aw_phase(v);
    w_phase(v.len + 1);
    b_phase(v.resp, hold);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 1);
    chk({tag, "_wready"}, 32'(wready), 0);
    chk({tag, "_bvalid"}, 32'(bvalid), 0);
    chk({tag, "_bid"}, 32'(bid), 0);
    chk({tag, "_bresp"}, 32'(bresp), 0);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_wen"}, 32'(ram_wen), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    vec_t v;
    clk = 0; rstn = 1;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    for (int i = 0; i < WORDS; i++) begin dut_mem[i] = 0; exp_mem[i] = 0; end

    //          id     addr            len sz bu strb   wbase           last resp
    tbl[0]  = '{4'd3,  32'h0000_0100,  7,  2, 1, 4'hF, 32'h0000_00A0,  7, RESP_OKAY};
    tbl[1]  = '{4'd5,  32'h0000_0038,  3,  2, 2, 4'hF, 32'h0000_00B0,  3, RESP_OKAY};
    tbl[2]  = '{4'd2,  32'h0000_FFFC,  1,  2, 1, 4'hF, 32'h0000_00C0,  1, RESP_DECERR};
    tbl[3]  = '{4'd4,  32'h0000_0400,  3,  2, 1, 4'hF, 32'h0000_00D0,  2, RESP_SLVERR};
    tbl[4]  = '{4'd6,  32'h0000_0500,  0,  3, 1, 4'hF, 32'h0000_00E0,  0, RESP_SLVERR};
    tbl[5]  = '{4'd7,  32'h0000_0540,  2,  2, 2, 4'hF, 32'h0000_00E8,  2, RESP_SLVERR};
    tbl[6]  = '{4'd8,  32'h0000_0580,  1,  2, 3, 4'hF, 32'h0000_00F0,  1, RESP_SLVERR};
    tbl[7]  = '{4'd9,  32'h0000_0600,  3,  2, 0, 4'h3, 32'h1111_0100,  3, RESP_OKAY};
    tbl[8]  = '{4'd10, 32'h0000_0701,  3,  0, 1, 4'hA, 32'h2222_0200,  3, RESP_OKAY};
    tbl[9]  = '{4'd11, 32'h0002_0000,  0,  2, 1, 4'hF, 32'h0000_0300,  0, RESP_DECERR};
    tbl[10] = '{4'd12, 32'h0000_FFF8,  3,  2, 2, 4'hF, 32'h0000_0400,  3, RESP_OKAY};
    tbl[11] = '{4'd13, 32'h0000_FFF8,  3,  2, 1, 4'hF, 32'h0000_0410,  1, RESP_DECERR};
    tbl[12] = '{4'd14, 32'hFFFF_FFF8,  3,  2, 1, 4'hF, 32'h0000_0500,  3, RESP_DECERR};

    #2 rstn = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Byte strobes merge into a preloaded word
    dut_mem[32'h81] = 32'hFFFF_FFFF; exp_mem[32'h81] = 32'hFFFF_FFFF;
    v = '{4'd1, 32'h0000_0204, 0, 2, 0, 4'h6, 32'h1122_3344, 0, RESP_OKAY};
    run_vec(v, 0);
    chk("strb_merge", dut_mem[32'h81], 32'hFF22_33FF);

    for (int t = 0; t < 13; t++) begin
      run_vec(tbl[t], t % 3);
      if (t == 0) for (int i = 0; i < 8; i++) chk("incr8_word", dut_mem[32'h40 + i], 32'hA0 + 32'(i));
      if (t == 1) begin
        chk("wrap_w0c", dut_mem[32'h0C], 32'hB2);
        chk("wrap_w0d", dut_mem[32'h0D], 32'hB3);
        chk("wrap_w0e", dut_mem[32'h0E], 32'hB0);
        chk("wrap_w0f", dut_mem[32'h0F], 32'hB1);
      end
      if (t == 2) chk("top_word", dut_mem[32'h3FFF], 32'hC0);
      if (t == 3) chk("late_last_word", dut_mem[32'h103], 32'hD3);
    end

    // B back-pressure with a competing AW, then reset three beats into that burst
    v = '{4'd15, 32'h0000_0900, 0, 2, 1, 4'hF, 32'h0000_0900, 0, RESP_OKAY};
    aw_phase(v);
    w_phase(1);
    awid = 4'd9; awaddr = 32'h800; awlen = 4'd7; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    b_phase(RESP_OKAY, 5);
    g_v = '{4'd9, 32'h0000_0800, 7, 2, 1, 4'hF, 32'h0000_0700, 7, RESP_OKAY};
    g_bad = 1'b0;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    chk("pend_aw_taken", 32'(awready), 0);
    w_phase(3);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    rstn = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); @(negedge clk);
    chk("midrst_no_write", dut_mem[32'h203], exp_mem[32'h203]);
    chk("midrst_prev_beat", dut_mem[32'h202], 32'h702);
    rstn = 1'b1; wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_awready", 32'(awready), 1);
      chk("postrst_bvalid", 32'(bvalid), 0);
    end

    for (int r = 0; r < 40; r++) begin
      v.id    = 4'($urandom_range(0, 15));
      v.size  = $urandom_range(0, 3);
      v.burst = $urandom_range(0, 3);
      v.len   = $urandom_range(0, 15);
      if (v.burst == 2 && is_bad(v.len, v.size, v.burst)) v.addr = 32'($urandom_range(0, 32'h7FFF));
      else v.addr = 32'($urandom_range(0, 32'h1_0400));
      v.addr    = v.addr & ~((32'd1 << v.size) - 32'd1);
      v.strb    = 4'($urandom_range(0, 15));
      v.wbase   = $urandom;
      v.last_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : v.len;
      v.resp    = model_resp(v);
      run_vec(v, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
